// File: rtl/psram_bus_adapter.sv
// psram_bus_adapter: queues 64-bit SoC bus requests and runs them one at a
// time through the PSRAM core handshake, swapping byte lanes between the
// little-endian bus and the core's MSB-first shifters.
module psram_bus_adapter #(
    parameter int          REQ_DEPTH = 2,
    parameter logic [31:0] ADDR_MASK = 32'h00FF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cfg_en_i,
    input  logic        mem_valid_i,
    output logic        mem_ready_o,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [63:0] mem_wdata_i,
    input  logic [7:0]  mem_wstrb_i,
    output logic        mem_rvalid_o,
    input  logic        mem_rready_i,
    output logic [63:0] mem_rdata_o,
    output logic        mem_err_o,
    output logic        xfer_valid_o,
    output logic        xfer_rdwr_o,
    input  logic        xfer_ready_i,
    input  logic        xfer_done_i,
    output logic [31:0] bus_addr_o,
    output logic [63:0] bus_wr_data_o,
    output logic [7:0]  bus_wr_mask_o,
    input  logic [63:0] bus_rd_data_i
);

    localparam int PW = $clog2(REQ_DEPTH);

    // Address bits [2:0] are never stored, so only the dword address is queued.
    typedef struct packed {
        logic        we;
        logic [28:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } req_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    // Byte lane i of the bus maps to the most-significant-first byte i on the core.
    function automatic logic [63:0] swap_lanes(input logic [63:0] d);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[63-8*i -: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [7:0] rev_mask(input logic [7:0] m);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[7-i] = m[i];
        return r;
    endfunction

    req_t        fifo_mem [REQ_DEPTH];
    logic [PW:0] wr_ptr, rd_ptr;
    logic        full, empty, push, pop;
    req_t        head;

    state_t      state, state_nxt;

    logic        xfer_valid_q, rvalid_q, rdwr_q, err_q;
    logic [31:0] addr_q;
    logic [63:0] wdata_q, rdata_q;
    logic [7:0]  mask_q;

    logic        unused_addr_bits;
    assign unused_addr_bits = ^mem_addr_i[2:0];

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign push  = mem_valid_i && !full;
    assign head  = fifo_mem[rd_ptr[PW-1:0]];

    // Request FIFO storage and pointers; ready reflects pre-pop occupancy.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr[PW-1:0]] <= '{we: mem_we_i, addr: mem_addr_i[31:3],
                                              wdata: mem_wdata_i, wstrb: mem_wstrb_i};
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state and pop decision; a head that cannot issue yet stays queued.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    if (!cfg_en_i || (head.we && head.wstrb == 8'h00)) begin
                        pop       = 1'b1;
                        state_nxt = RESP;
                    end else if (xfer_ready_i) begin
                        pop       = 1'b1;
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE:   if (!xfer_ready_i) state_nxt = WAIT;
            WAIT:    if (xfer_done_i)   state_nxt = RESP;
            RESP:    if (mem_rready_i)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Command holding registers, response registers and registered strobes.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            xfer_valid_q <= 1'b0;
            rvalid_q     <= 1'b0;
            rdwr_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mask_q       <= 8'hFF;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            xfer_valid_q <= (state_nxt == ISSUE);
            rvalid_q     <= (state_nxt == RESP);
            if (pop) begin
                rdwr_q  <= ~head.we;
                addr_q  <= {head.addr & ADDR_MASK[31:3], 3'b000};
                wdata_q <= swap_lanes(head.wdata);
                mask_q  <= head.we ? rev_mask(head.wstrb) : 8'hFF;
                // Bypassed requests respond with these; issued ones overwrite on done.
                rdata_q <= '0;
                err_q   <= ~cfg_en_i;
            end else if (state == WAIT && xfer_done_i) begin
                rdata_q <= rdwr_q ? swap_lanes(bus_rd_data_i) : 64'h0;
                err_q   <= 1'b0;
            end
        end
    end

    assign mem_ready_o   = !full;
    assign mem_rvalid_o  = rvalid_q;
    assign mem_rdata_o   = rdata_q;
    assign mem_err_o     = err_q;
    assign xfer_valid_o  = xfer_valid_q;
    assign xfer_rdwr_o   = rdwr_q;
    assign bus_addr_o    = addr_q;
    assign bus_wr_data_o = wdata_q;
    assign bus_wr_mask_o = mask_q;

endmodule

// File: tb/tb_psram_bus_adapter.sv
// tb_psram_bus_adapter: directed vectors through one request at a time, plus
// hand sequences for backpressure, stray done pulses and mid-transfer reset.
module tb_psram_bus_adapter;

    logic        clk_i = 1'b0;
    logic        rst_n_i, cfg_en_i, mem_valid_i, mem_we_i, mem_rready_i;
    logic        xfer_ready_i, xfer_done_i;
    logic [31:0] mem_addr_i;
    logic [63:0] mem_wdata_i, bus_rd_data_i;
    logic [7:0]  mem_wstrb_i;
    logic        mem_ready_o, mem_rvalid_o, mem_err_o, xfer_valid_o, xfer_rdwr_o;
    logic [63:0] mem_rdata_o, bus_wr_data_o;
    logic [31:0] bus_addr_o;
    logic [7:0]  bus_wr_mask_o;

    localparam logic [63:0] JUNK = 64'hA5A5_5A5A_C3C3_3C3C;

    int checks = 0;
    int failures = 0;

    psram_bus_adapter #(.REQ_DEPTH(2), .ADDR_MASK(32'h00FF_FFFF)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .cfg_en_i(cfg_en_i),
        .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o), .mem_we_i(mem_we_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_wstrb_i(mem_wstrb_i),
        .mem_rvalid_o(mem_rvalid_o), .mem_rready_i(mem_rready_i),
        .mem_rdata_o(mem_rdata_o), .mem_err_o(mem_err_o),
        .xfer_valid_o(xfer_valid_o), .xfer_rdwr_o(xfer_rdwr_o),
        .xfer_ready_i(xfer_ready_i), .xfer_done_i(xfer_done_i),
        .bus_addr_o(bus_addr_o), .bus_wr_data_o(bus_wr_data_o),
        .bus_wr_mask_o(bus_wr_mask_o), .bus_rd_data_i(bus_rd_data_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic        cfg;
        logic [63:0] core;
        logic        byp;
        logic [31:0] e_addr;
        logic [63:0] e_wdata;
        logic [7:0]  e_mask;
        logic [63:0] e_rdata;
        logic        e_err;
    } vec_t;

    vec_t vecs [7];

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive_req(input logic we, input logic [31:0] addr,
                             input logic [63:0] wdata, input logic [7:0] wstrb);
        mem_valid_i = 1'b1;
        mem_we_i    = we;
        mem_addr_i  = addr;
        mem_wdata_i = wdata;
        mem_wstrb_i = wstrb;
    endtask

    // Core model for one issued transfer: accept, wait, pulse done, then drain response.
    task automatic serve(input logic [31:0] e_addr, input logic [63:0] e_wdata,
                         input logic [7:0] e_mask, input logic e_rdwr,
                         input logic [63:0] core, input logic [63:0] e_rdata, input int hold);
        int n = 0;
        while (!xfer_valid_o && n < 50) begin
            step();
            n++;
        end
        chk("issue_seen", 64'(xfer_valid_o), 64'(1'b1));
        chk("bus_addr", 64'(bus_addr_o), 64'(e_addr));
        chk("bus_wr_data", bus_wr_data_o, e_wdata);
        chk("bus_wr_mask", 64'(bus_wr_mask_o), 64'(e_mask));
        chk("xfer_rdwr", 64'(xfer_rdwr_o), 64'(e_rdwr));
        xfer_ready_i = 1'b0;
        step();
        chk("valid_fall", 64'(xfer_valid_o), 64'(1'b0));
        chk("no_rvalid_wait", 64'(mem_rvalid_o), 64'(1'b0));
        step();
        xfer_done_i   = 1'b1;
        bus_rd_data_i = core;
        chk("addr_stable", 64'(bus_addr_o), 64'(e_addr));
        chk("wdata_stable", bus_wr_data_o, e_wdata);
        step();
        xfer_done_i   = 1'b0;
        bus_rd_data_i = JUNK;
        xfer_ready_i  = 1'b1;
        chk("rvalid_after_done", 64'(mem_rvalid_o), 64'(1'b1));
        chk("rdata", mem_rdata_o, e_rdata);
        chk("err", 64'(mem_err_o), 64'(1'b0));
        for (int h = 0; h < hold; h++) begin
            step();
            chk("hold_rvalid", 64'(mem_rvalid_o), 64'(1'b1));
            chk("hold_rdata", mem_rdata_o, e_rdata);
            chk("hold_no_issue", 64'(xfer_valid_o), 64'(1'b0));
        end
        mem_rready_i = 1'b1;
        step();
        mem_rready_i = 1'b0;
        chk("rvalid_drop", 64'(mem_rvalid_o), 64'(1'b0));
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h0000_1008, 64'h0807_0605_0403_0201, 8'h0F, 1'b1, 64'h0, 1'b0,
                    32'h0000_1008, 64'h0102_0304_0506_0708, 8'hF0, 64'h0, 1'b0};
        vecs[1] = '{1'b0, 32'h0100_0013, 64'h0, 8'h00, 1'b1, 64'h1122_3344_5566_7788, 1'b0,
                    32'h0000_0010, 64'h0, 8'hFF, 64'h8877_6655_4433_2211, 1'b0};
        vecs[2] = '{1'b1, 32'hFFFF_FFFF, 64'hDEAD_BEEF_CAFE_BABE, 8'h35, 1'b1, 64'h0, 1'b0,
                    32'h00FF_FFF8, 64'hBEBA_FECA_EFBE_ADDE, 8'hAC, 64'h0, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_0100, 64'h0, 8'h00, 1'b0, 64'h0, 1'b1,
                    32'h0, 64'h0, 8'h0, 64'h0, 1'b1};
        vecs[4] = '{1'b1, 32'h0000_0200, 64'h1234, 8'h00, 1'b1, 64'h0, 1'b1,
                    32'h0, 64'h0, 8'h0, 64'h0, 1'b0};
        vecs[5] = '{1'b1, 32'h0000_0300, 64'h5678, 8'hFF, 1'b0, 64'h0, 1'b1,
                    32'h0, 64'h0, 8'h0, 64'h0, 1'b1};
        vecs[6] = '{1'b0, 32'h0000_0008, 64'h0, 8'h00, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0,
                    32'h0000_0008, 64'h0, 8'hFF, 64'hEFCD_AB89_6745_2301, 1'b0};

        rst_n_i = 1'b0; cfg_en_i = 1'b1; mem_valid_i = 1'b0; mem_rready_i = 1'b0;
        xfer_ready_i = 1'b1; xfer_done_i = 1'b0; bus_rd_data_i = JUNK;
        drive_req(1'b0, 32'h0, 64'h0, 8'h0);
        mem_valid_i = 1'b0;
        step(); step();
        rst_n_i = 1'b1;

        chk("rst_ready", 64'(mem_ready_o), 64'(1'b1));
        chk("rst_rvalid", 64'(mem_rvalid_o), 64'(1'b0));
        chk("rst_xvalid", 64'(xfer_valid_o), 64'(1'b0));
        chk("rst_rdwr", 64'(xfer_rdwr_o), 64'(1'b0));
        chk("rst_addr", 64'(bus_addr_o), 64'h0);
        chk("rst_wdata", bus_wr_data_o, 64'h0);
        chk("rst_mask", 64'(bus_wr_mask_o), 64'hFF);
        chk("rst_rdata", mem_rdata_o, 64'h0);
        chk("rst_err", 64'(mem_err_o), 64'(1'b0));

        // Single requests with exact latency checks.
        for (int v = 0; v < 7; v++) begin
            cfg_en_i = vecs[v].cfg;
            drive_req(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].wstrb);
            chk("push_ready", 64'(mem_ready_o), 64'(1'b1));
            step();
            mem_valid_i = 1'b0;
            chk("plus1_xvalid", 64'(xfer_valid_o), 64'(1'b0));
            chk("plus1_rvalid", 64'(mem_rvalid_o), 64'(1'b0));
            step();
            if (vecs[v].byp) begin
                chk("byp_rvalid", 64'(mem_rvalid_o), 64'(1'b1));
                chk("byp_xvalid", 64'(xfer_valid_o), 64'(1'b0));
                chk("byp_rdata", mem_rdata_o, vecs[v].e_rdata);
                chk("byp_err", 64'(mem_err_o), 64'(vecs[v].e_err));
                mem_rready_i = 1'b1;
                step();
                mem_rready_i = 1'b0;
                chk("byp_rvalid_drop", 64'(mem_rvalid_o), 64'(1'b0));
                chk("byp_xvalid_after", 64'(xfer_valid_o), 64'(1'b0));
            end else begin
                chk("issue_latency", 64'(xfer_valid_o), 64'(1'b1));
                serve(vecs[v].e_addr, vecs[v].e_wdata, vecs[v].e_mask, ~vecs[v].we,
                      vecs[v].core, vecs[v].e_rdata, 0);
            end
        end
        cfg_en_i = 1'b1;

        // Backpressure: core busy, three requests into a two-deep FIFO.
        xfer_ready_i = 1'b0;
        drive_req(1'b0, 32'h0000_0020, 64'h0, 8'h00);
        chk("bp_ready_a", 64'(mem_ready_o), 64'(1'b1));
        step();
        drive_req(1'b1, 32'h0000_0028, 64'h0000_0000_0000_00AB, 8'h01);
        chk("bp_ready_b", 64'(mem_ready_o), 64'(1'b1));
        step();
        drive_req(1'b0, 32'h0000_0030, 64'h0, 8'h00);
        chk("bp_full", 64'(mem_ready_o), 64'(1'b0));
        step();
        chk("bp_full_hold", 64'(mem_ready_o), 64'(1'b0));
        chk("bp_no_issue", 64'(xfer_valid_o), 64'(1'b0));
        xfer_ready_i = 1'b1;
        chk("bp_full_at_pop", 64'(mem_ready_o), 64'(1'b0));
        step();
        chk("bp_ready_after_pop", 64'(mem_ready_o), 64'(1'b1));
        step();
        mem_valid_i = 1'b0;
        serve(32'h0000_0020, 64'h0, 8'hFF, 1'b1, 64'h0102_0304_0506_0708,
              64'h0807_0605_0403_0201, 5);
        serve(32'h0000_0028, 64'hAB00_0000_0000_0000, 8'h80, 1'b0, JUNK, 64'h0, 0);
        serve(32'h0000_0030, 64'h0, 8'hFF, 1'b1, 64'hFFEE_DDCC_BBAA_9988,
              64'h8899_AABB_CCDD_EEFF, 0);

        // Stray done pulse in IDLE with the FIFO empty.
        xfer_done_i = 1'b1;
        step();
        xfer_done_i = 1'b0;
        chk("stray_idle_rvalid", 64'(mem_rvalid_o), 64'(1'b0));
        chk("stray_idle_xvalid", 64'(xfer_valid_o), 64'(1'b0));
        step();
        chk("stray_idle_rvalid2", 64'(mem_rvalid_o), 64'(1'b0));

        // Stray done pulse while a disabled-read response is pending.
        cfg_en_i = 1'b0;
        drive_req(1'b0, 32'h0000_0040, 64'h0, 8'h00);
        step();
        mem_valid_i = 1'b0;
        step();
        chk("stray_resp_rvalid", 64'(mem_rvalid_o), 64'(1'b1));
        xfer_done_i   = 1'b1;
        bus_rd_data_i = 64'h1111_2222_3333_4444;
        step();
        xfer_done_i   = 1'b0;
        bus_rd_data_i = JUNK;
        chk("stray_resp_hold", 64'(mem_rvalid_o), 64'(1'b1));
        chk("stray_resp_err", 64'(mem_err_o), 64'(1'b1));
        chk("stray_resp_rdata", mem_rdata_o, 64'h0);
        mem_rready_i = 1'b1;
        step();
        mem_rready_i = 1'b0;
        chk("stray_resp_drop", 64'(mem_rvalid_o), 64'(1'b0));
        cfg_en_i = 1'b1;

        // Reset during WAIT with a second request queued.
        drive_req(1'b1, 32'h0000_0048, 64'h1, 8'hFF);
        step();
        drive_req(1'b1, 32'h0000_0050, 64'h2, 8'hFF);
        step();
        mem_valid_i = 1'b0;
        chk("rw_issue", 64'(xfer_valid_o), 64'(1'b1));
        xfer_ready_i = 1'b0;
        step();
        rst_n_i = 1'b0;
        step();
        chk("rw_xvalid", 64'(xfer_valid_o), 64'(1'b0));
        chk("rw_ready", 64'(mem_ready_o), 64'(1'b1));
        chk("rw_rvalid", 64'(mem_rvalid_o), 64'(1'b0));
        chk("rw_mask", 64'(bus_wr_mask_o), 64'hFF);
        rst_n_i = 1'b1;
        xfer_ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("rw_empty_xvalid", 64'(xfer_valid_o), 64'(1'b0));
            chk("rw_empty_rvalid", 64'(mem_rvalid_o), 64'(1'b0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
